vga_ctrl: RTL
=============

VGA_CTRL -- requirements
Module: vga_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  H_SYNC, 96, hsync pulse width in clocks
  H_BACK, 48, horizontal back porch
  H_VALID, 640, active pixels per line
  H_TOTAL, 800, clocks per line
  V_SYNC, 2, vsync pulse width in lines
  V_BACK, 33, vertical back porch
  V_VALID, 480, active lines per frame
  V_TOTAL, 525, lines per frame
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  input  1  25 MHz pixel clock
  rst_n  input  1  reset, asynchronous, active-low
  pix_data  input  16  RGB565 pixel from upstream generator
  pix_data_req  output  1  request for pixel at pix_x/pix_y
  pix_x  output  10  requested column
  pix_y  output  10  requested row
  hsync  output  1  horizontal sync, active-high
  vsync  output  1  vertical sync, active-high
  rgb  output  16  RGB565 to DAC / downstream stage
  frame_start  output  1  one-clock pulse at frame origin
REQ-003 Design SHALL use one clock (clk); reset SHALL be asynchronous and active-low (rst_n).

Function
REQ-004 cnt_h (10 bit) SHALL increment every clk, wrapping H_TOTAL-1 -> 0.
REQ-005 cnt_v (10 bit) SHALL increment only when cnt_h == H_TOTAL-1, wrapping V_TOTAL-1 -> 0 on that same clock.
REQ-006 hsync SHALL be 1 iff cnt_h < H_SYNC; vsync SHALL be 1 iff cnt_v < V_SYNC; both decoded from current counters, zero latency.
REQ-007 Active region SHALL be HA = H_SYNC+H_BACK (144) <= cnt_h < HA+H_VALID (784) and VA = V_SYNC+V_BACK (35) <= cnt_v < VA+V_VALID (515).
REQ-008 pix_data_req SHALL assert one clock before each active pixel: cnt_h in [HA-1, HA+H_VALID-2] (143..782) and cnt_v in active rows.
REQ-009 When pix_data_req=1, pix_x SHALL be cnt_h-(HA-1) (0..639) and pix_y SHALL be cnt_v-VA (0..479); otherwise both SHALL be 10'h3FF.
REQ-010 Upstream SHALL return pix_data registered one clock after pix_data_req; rgb SHALL equal pix_data while in active region, else 16'h0000 (blanking forced black).
REQ-011 frame_start SHALL be 1 for exactly the clock where cnt_h==0 and cnt_v==0, excluding the clock(s) while rst_n is low.
REQ-012 Subtractions SHALL be 10-bit unsigned; no counter SHALL exceed TOTAL-1 under any condition.
REQ-013 Line/frame wrap SHALL be seamless: no idle clock between cnt_h=799 and 0, nor cnt_v=524 and 0.
REQ-014 Exactly 640 requests per active line and 640*480 per frame SHALL be issued.

Reset
REQ-015 While rst_n=0: cnt_h=0, cnt_v=0, thus hsync=1, vsync=1, rgb=0, pix_data_req=0, pix_x=pix_y=10'h3FF, frame_start=0.
REQ-016 Reset asserted mid-frame SHALL immediately (asynchronously) force REQ-015 values; after release counting SHALL restart from cnt_h=0, cnt_v=0 on the first rising clk edge, with frame_start pulsing at the first full frame wrap (cnt_v 524->0).

Verification
REQ-017 Release reset, run 2 frames -> hsync period 800 clk, high 96; vsync period 420000 clk, high 1600 clk.
REQ-018 Line 35: pix_data_req rises at cnt_h=143 with pix_x=0, pix_y=0; falls after cnt_h=782 with last pix_x=639.
REQ-019 Upstream returns pix_data = {pix_y[4:0], pix_x[5:0], pix_y[4:0]} registered -> rgb at cnt_h=144 matches (0,0) value; rgb=0 at cnt_h=143 and 784.
REQ-020 Count requests over one frame -> exactly 307200; none on rows 0..34 or 515..524.
REQ-021 Assert rst_n low at cnt_v=200, cnt_h=400 for 3 clocks -> outputs immediately at REQ-015 values; after release cnt_h/cnt_v restart at 0.
REQ-022 Observe frame_start over 3 frames -> one single-clock pulse per 420000 clocks, coincident with hsync and vsync rising.

Source files
------------

// File: rtl/vga_ctrl.sv
// vga_ctrl: VGA timing generator with one-clock-ahead pixel request and blanking
//
// Ports:
//   clk           in   pixel clock
//   rst_n         in   asynchronous active-low reset
//   pix_data      in   16-bit RGB565 pixel, registered by upstream one clock after pix_data_req
//   pix_data_req  out  request for the pixel at pix_x/pix_y
//   pix_x         out  requested column (10'h3FF when no request)
//   pix_y         out  requested row (10'h3FF when no request)
//   hsync         out  horizontal sync, active-high
//   vsync         out  vertical sync, active-high
//   rgb           out  pixel to the DAC, black outside the active region
//   frame_start   out  one-clock pulse at the frame origin
module vga_ctrl #(
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_VALID = 640,
    parameter int H_TOTAL = 800,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_VALID = 480,
    parameter int V_TOTAL = 525
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pix_data,
    output logic        pix_data_req,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic [15:0] rgb,
    output logic        frame_start
);
    localparam logic [9:0] HS  = 10'(H_SYNC);
    localparam logic [9:0] VS  = 10'(V_SYNC);
    localparam logic [9:0] HA  = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] HE  = 10'(H_SYNC + H_BACK + H_VALID);
    localparam logic [9:0] VA  = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] VE  = 10'(V_SYNC + V_BACK + V_VALID);
    localparam logic [9:0] HT1 = 10'(H_TOTAL - 1);
    localparam logic [9:0] VT1 = 10'(V_TOTAL - 1);
    localparam logic [9:0] HR0 = HA - 10'd1;
    localparam logic [9:0] HR1 = HE - 10'd2;

    logic [9:0] cnt_h;
    logic [9:0] cnt_v;
    logic       h_end;
    logic       v_end;
    logic       v_act;
    logic       act;

    // >= rather than == so a counter can never run past TOTAL-1
    assign h_end = cnt_h >= HT1;
    assign v_end = cnt_v >= VT1;

    // frame_start is registered on the wrap into (0,0), so the partial
    // clock at (0,0) right after reset release never produces a pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_h       <= '0;
            cnt_v       <= '0;
            frame_start <= 1'b0;
        end else begin
            cnt_h       <= h_end ? '0 : cnt_h + 10'd1;
            if (h_end)
                cnt_v   <= v_end ? '0 : cnt_v + 10'd1;
            frame_start <= h_end && v_end;
        end
    end

    assign hsync = cnt_h < HS;
    assign vsync = cnt_v < VS;
    assign v_act = cnt_v >= VA && cnt_v < VE;
    assign act   = cnt_h >= HA && cnt_h < HE && v_act;

    // requests lead the active window by one clock to cover upstream's register
    assign pix_data_req = cnt_h >= HR0 && cnt_h <= HR1 && v_act;
    assign pix_x        = pix_data_req ? cnt_h - HR0 : 10'h3FF;
    assign pix_y        = pix_data_req ? cnt_v - VA : 10'h3FF;
    assign rgb          = act ? pix_data : 16'h0000;
endmodule
